usb_rw_ctrl: RTL and testbench

Parametrised host-side read/write transaction controller for the USB memory-page link. It sits between the testbench/task interface and the USB protocol FSM. For each page it issues an address transaction (OUT token plus DATA packet carrying the page number), then a data transaction: IN for reads, OUT for writes. Compared with the single-shot controller it adds multi-page bursts with page auto-increment, bounded retry of failed protocol phases, valid/ready data handshakes, and a return to IDLE after every task.

---
 rtl/usb_rw_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_usb_rw_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rw_ctrl.sv
`timescale 1ns/1ps
// Host-side USB page read/write controller: address phase then data phase per page,
// with burst auto-increment. Optional bounded phase retry under macro USB_RW_RETRY_EN.
module usb_rw_ctrl #(
  parameter int         DATA_W    = 64,
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter logic [3:0] ENDP_ADDR = 4'b0010,
  parameter logic [3:0] ENDP_DATA = 4'b0001,
  parameter int         MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [1:0]        tsk,
  input  logic [15:0]       mempage,
  input  logic [3:0]        burst_len,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] data_to_tb,
  output logic              rd_valid,
  output logic              task_busy,
  output logic              task_done,
  output logic              task_success,
  output logic [18:0]       token_pkt_out,
  output logic [DATA_W+7:0] data_pkt_out,
  output logic              ptcl_start,
  input  logic              ptcl_ready,
  input  logic              ptcl_done,
  input  logic              ptcl_success,
  input  logic [DATA_W-1:0] ptcl_data
);

  localparam logic [7:0] PID_OUT  = 8'h87;
  localparam logic [7:0] PID_IN   = 8'h96;
  localparam logic [7:0] PID_DATA = 8'hC3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_REQ, S_ADDR_WAIT, S_WR_FETCH, S_DATA_REQ, S_DATA_WAIT, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       cur_page_q, cur_page_d;
  logic [3:0]        pages_left_q, pages_left_d;
  logic [DATA_W-1:0] wr_buf_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic              wr_buf_en, rd_capture;
  logic              retry_ok, retry_clr, retry_inc;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

`ifdef USB_RW_RETRY_EN
  logic [3:0] retry_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         retry_cnt_q <= '0;
    else if (retry_clr) retry_cnt_q <= '0;
    else if (retry_inc) retry_cnt_q <= retry_cnt_q + 4'd1;
  end

  assign retry_ok = (retry_cnt_q < 4'(MAX_RETRY));
`else
  logic unused_retry;
  assign unused_retry = retry_clr ^ retry_inc;
  assign retry_ok     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    cur_page_d   = cur_page_q;
    pages_left_d = pages_left_q;
    wr_buf_en    = 1'b0;
    rd_capture   = 1'b0;
    retry_clr    = 1'b0;
    retry_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tsk == 2'b01 || tsk == 2'b10) begin
          state_d      = S_ADDR_REQ;
          is_wr_d      = tsk[1];
          cur_page_d   = mempage;
          pages_left_d = burst_len;
          retry_clr    = 1'b1;
        end
      end
      S_ADDR_REQ: if (ptcl_ready) state_d = S_ADDR_WAIT;
      S_ADDR_WAIT: begin
        if (ptcl_done) begin
          if (ptcl_success) begin
            state_d   = is_wr_q ? S_WR_FETCH : S_DATA_REQ;
            retry_clr = 1'b1;
          end else if (retry_ok) begin
            state_d   = S_ADDR_REQ;
            retry_inc = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WR_FETCH: begin
        if (wr_valid) begin
          wr_buf_en = 1'b1;
          state_d   = S_DATA_REQ;
        end
      end
      S_DATA_REQ: if (ptcl_ready) state_d = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (ptcl_done) begin
          if (ptcl_success) begin
            rd_capture = !is_wr_q;
            if (pages_left_q == 4'd0) begin
              state_d = S_DONE;
            end else begin
              state_d      = S_ADDR_REQ;
              cur_page_d   = cur_page_q + 16'd1;
              pages_left_d = pages_left_q - 4'd1;
              retry_clr    = 1'b1;
            end
          end else if (retry_ok) begin
            // wr_buf is kept, so a write retry resends the same payload
            state_d   = S_DATA_REQ;
            retry_inc = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      is_wr_q      <= 1'b0;
      cur_page_q   <= '0;
      pages_left_q <= '0;
      data_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      cur_page_q   <= cur_page_d;
      pages_left_q <= pages_left_d;
      rd_valid_q   <= rd_capture;
      if (rd_capture) data_q <= bitrev(ptcl_data);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_buf_en) wr_buf_q <= data_in;
  end

  always_comb begin
    token_pkt_out = '0;
    data_pkt_out  = '0;
    case (state_q)
      S_ADDR_REQ, S_ADDR_WAIT: begin
        token_pkt_out = {PID_OUT, DEV_ADDR, ENDP_ADDR};
        data_pkt_out  = {PID_DATA, bitrev({cur_page_q, {(DATA_W-16){1'b0}}})};
      end
      S_DATA_REQ, S_DATA_WAIT: begin
        token_pkt_out = {(is_wr_q ? PID_OUT : PID_IN), DEV_ADDR, ENDP_DATA};
        if (is_wr_q) data_pkt_out = {PID_DATA, bitrev(wr_buf_q)};
      end
      default: ;
    endcase
  end

  assign ptcl_start   = (state_q == S_ADDR_REQ || state_q == S_DATA_REQ) && ptcl_ready;
  assign wr_ready     = (state_q == S_WR_FETCH);
  assign task_busy    = (state_q != S_IDLE);
  assign task_done    = (state_q == S_DONE) || (state_q == S_ERR);
  assign task_success = (state_q == S_DONE);
  assign rd_valid     = rd_valid_q;
  assign data_to_tb   = data_q;

endmodule

// File: tb/tb_usb_rw_ctrl.sv
`timescale 1ns/1ps
// Randomised bench for usb_rw_ctrl: a transaction-level model predicts every protocol
// request, read word and task result; one per-cycle loop drives and compares.
module tb_usb_rw_ctrl;
  localparam int         DW  = 64;
  localparam logic [6:0] DEV = 7'b1010000;
`ifdef USB_RW_RETRY_EN
  localparam int EFF_MAXR = 3;
`else
  localparam int EFF_MAXR = 0;
`endif

  logic          clk, rst_b;
  logic [1:0]    tsk;
  logic [15:0]   mempage;
  logic [3:0]    burst_len;
  logic [DW-1:0] data_in, data_to_tb, ptcl_data;
  logic          wr_valid, wr_ready, rd_valid, task_busy, task_done, task_success;
  logic [18:0]   token_pkt_out;
  logic [DW+7:0] data_pkt_out;
  logic          ptcl_start, ptcl_ready, ptcl_done, ptcl_success;

  usb_rw_ctrl dut (
    .clk(clk), .rst_b(rst_b), .tsk(tsk), .mempage(mempage), .burst_len(burst_len),
    .data_in(data_in), .wr_valid(wr_valid), .wr_ready(wr_ready), .data_to_tb(data_to_tb),
    .rd_valid(rd_valid), .task_busy(task_busy), .task_done(task_done),
    .task_success(task_success), .token_pkt_out(token_pkt_out), .data_pkt_out(data_pkt_out),
    .ptcl_start(ptcl_start), .ptcl_ready(ptcl_ready), .ptcl_done(ptcl_done),
    .ptcl_success(ptcl_success), .ptcl_data(ptcl_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0]   tok;
    logic [DW+7:0] pkt;
    logic          fail;
    logic [DW-1:0] rdata;
    logic          isrd;
  } req_t;

  req_t          req_q[$];
  req_t          cur;
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [18:0]   seen_tok[$];
  logic [DW+7:0] seen_pkt[$];
  int            fa[16], fd[16];
  logic [DW-1:0] wd[16], rd[16];

  int  n_cmp, n_err;
  int  cyc, launch_cyc, first_start_cyc, last_done_cyc;
  bit  in_task, resp_active, force_ready, no_spur, hold_resp;
  int  resp_cnt, resp_max;
  bit  exp_success, last_success;
  int  exp_fetch, fetch_cnt, done_cnt, rd_cnt, start_cnt;
  logic [DW-1:0] last_rd;
  logic [1:0]    tsk_drive;
  logic [15:0]   page_drive;
  logic [3:0]    blen_drive;

  function automatic logic [DW-1:0] brev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Expected protocol requests of one task, from page/burst and the planned phase failures.
  function automatic void build(input bit wr, input logic [15:0] page, input logic [3:0] blen);
    logic [15:0] pg;
    req_t r;
    int n;
    pg = page;
    exp_success = 1'b1;
    exp_fetch = 0;
    for (int i = 0; i <= int'(blen); i++) begin
      n = (fa[i] > EFF_MAXR) ? EFF_MAXR + 1 : fa[i] + 1;
      for (int a = 0; a < n; a++) begin
        r.tok = {8'h87, DEV, 4'h2};
        r.pkt = {8'hC3, brev({pg, 48'h0})};
        r.fail = (a < fa[i]);
        r.rdata = '0;
        r.isrd = 1'b0;
        req_q.push_back(r);
      end
      if (fa[i] > EFF_MAXR) begin exp_success = 1'b0; break; end
      if (wr) exp_fetch++;
      n = (fd[i] > EFF_MAXR) ? EFF_MAXR + 1 : fd[i] + 1;
      for (int a = 0; a < n; a++) begin
        r.tok = {(wr ? 8'h87 : 8'h96), DEV, 4'h1};
        r.pkt = wr ? {8'hC3, brev(wd[i])} : 72'h0;
        r.fail = (a < fd[i]);
        r.rdata = rd[i];
        r.isrd = !wr;
        req_q.push_back(r);
      end
      if (fd[i] > EFF_MAXR) begin exp_success = 1'b0; break; end
      pg = pg + 16'd1;
    end
  endfunction

  task automatic step();
    bit was_active;
    @(negedge clk);
    cyc++;
    ptcl_done = 1'b0;
    ptcl_success = 1'b0;
    ptcl_data = {$urandom, $urandom};
    was_active = resp_active;
    if (resp_active) begin
      if (!hold_resp) begin
        if (resp_cnt == 0) begin
          ptcl_done = 1'b1;
          ptcl_success = !cur.fail;
          resp_active = 1'b0;
          last_done_cyc = cyc;
          if (cur.isrd && !cur.fail) begin
            ptcl_data = brev(cur.rdata);
            exp_rd_q.push_back(cur.rdata);
          end
        end else resp_cnt--;
      end
    end else if (!no_spur && $urandom_range(0, 7) == 0) begin
      ptcl_done = 1'b1;
      ptcl_success = 1'($urandom_range(0, 1));
    end
    ptcl_ready = resp_active ? 1'b0 : (force_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
    wr_valid = (wdata_q.size() > 0) && ($urandom_range(0, 1) == 1);
    data_in = wr_valid ? wdata_q[0] : {$urandom, $urandom};
    if (in_task) begin
      tsk = 2'($urandom_range(0, 3));
      mempage = 16'($urandom);
      burst_len = 4'($urandom);
    end else begin
      tsk = tsk_drive;
      mempage = page_drive;
      burst_len = blen_drive;
    end
    #1;
    if (was_active) begin
      check("no_start_in_wait", ptcl_start, 0);
      check("token_stable", token_pkt_out, cur.tok);
      check("data_pkt_stable", data_pkt_out, cur.pkt);
    end else if (ptcl_start) begin
      start_cnt++;
      if (start_cnt == 1) first_start_cyc = cyc;
      check("start_needs_ready", ptcl_ready, 1);
      seen_tok.push_back(token_pkt_out);
      seen_pkt.push_back(data_pkt_out);
      if (req_q.size() == 0) fail_msg("unexpected_start", "ptcl_start with no request predicted");
      else begin
        cur = req_q.pop_front();
        check("token", token_pkt_out, cur.tok);
        check("data_pkt", data_pkt_out, cur.pkt);
        resp_active = 1'b1;
        resp_cnt = $urandom_range(0, resp_max);
      end
    end
    if (wr_ready && wr_valid) begin
      fetch_cnt++;
      void'(wdata_q.pop_front());
    end
    if (rd_valid) begin
      rd_cnt++;
      last_rd = data_to_tb;
      check("rd_valid_latency", cyc - last_done_cyc, 1);
      if (exp_rd_q.size() == 0) fail_msg("unexpected_rd_valid", "rd_valid with no read predicted");
      else check("read_data", data_to_tb, exp_rd_q.pop_front());
    end
    if (task_done) begin
      done_cnt++;
      last_success = task_success;
      if (!in_task) fail_msg("spurious_task_done", "task_done while no task running");
      else begin
        check("done_latency", cyc - last_done_cyc, 1);
        check("task_success", task_success, exp_success);
        check("busy_at_done", task_busy, 1);
        check("requests_left", req_q.size(), 0);
        check("reads_left", exp_rd_q.size(), 0);
        check("fetch_count", fetch_cnt, exp_fetch);
        in_task = 1'b0;
      end
    end else if (in_task) begin
      check("busy", task_busy, 1);
    end else begin
      check("idle_busy", task_busy, 0);
      check("idle_token", token_pkt_out, 0);
      check("idle_data_pkt", data_pkt_out, 0);
      check("idle_start", ptcl_start, 0);
      check("idle_wr_ready", wr_ready, 0);
    end
  endtask

  task automatic reset_checks();
    check("rst_busy", task_busy, 0);
    check("rst_done", task_done, 0);
    check("rst_success", task_success, 0);
    check("rst_token", token_pkt_out, 0);
    check("rst_data_pkt", data_pkt_out, 0);
    check("rst_data_to_tb", data_to_tb, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_start", ptcl_start, 0);
  endtask

  task automatic clear_bench();
    req_q.delete(); exp_rd_q.delete(); wdata_q.delete();
    seen_tok.delete(); seen_pkt.delete();
    resp_active = 1'b0; hold_resp = 1'b0; in_task = 1'b0;
    fetch_cnt = 0; start_cnt = 0; rd_cnt = 0; done_cnt = 0;
    last_done_cyc = -100; first_start_cyc = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    reset_checks();
    clear_bench();
    repeat (3) step();
    rst_b = 1'b1;
  endtask

  task automatic launch(input bit wr, input logic [15:0] page, input logic [3:0] blen);
    clear_bench();
    build(wr, page, blen);
    if (wr) for (int i = 0; i <= int'(blen); i++) wdata_q.push_back(wd[i]);
    tsk_drive = wr ? 2'b10 : 2'b01;
    page_drive = page;
    blen_drive = blen;
    step();
    launch_cyc = cyc;
    in_task = 1'b1;
    tsk_drive = 2'b00;
  endtask

  task automatic run_task(input bit wr, input logic [15:0] page, input logic [3:0] blen);
    int budget;
    launch(wr, page, blen);
    budget = 0;
    while (in_task && budget < 3000) begin
      step();
      budget++;
    end
    if (in_task) begin
      fail_msg("timeout", "task_done never arrived");
      apply_reset();
    end
    step();
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      fa[i] = 0; fd[i] = 0;
      wd[i] = {$urandom, $urandom};
      rd[i] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_b = 1'b0; tsk = 2'b00; mempage = '0; burst_len = '0;
    data_in = '0; wr_valid = 1'b0; ptcl_ready = 1'b0; ptcl_done = 1'b0;
    ptcl_success = 1'b0; ptcl_data = '0;
    tsk_drive = 2'b00; page_drive = '0; blen_drive = '0;
    force_ready = 1'b1; no_spur = 1'b1; resp_max = 2;
    clear_bench();
    clear_plan();
    #1;
    reset_checks();
    repeat (3) step();
    rst_b = 1'b1;
    repeat (2) step();

    // single write, page 1234
    wd[0] = 64'hDEADBEEF00C0FFEE;
    run_task(1'b1, 16'h1234, 4'd0);
    check("w1_first_start_cycle", first_start_cyc, launch_cyc + 1);
    check("w1_addr_token", seen_tok[0], 19'h43D02);
    check("w1_addr_pkt", seen_pkt[0], 72'hC3_0000_0000_0000_2C48);
    check("w1_data_token", seen_tok[1], 19'h43D01);
    check("w1_data_pkt", seen_pkt[1], 72'hC3_77FF_0300_F77D_B57B);
    check("w1_success", last_success, 1);
    check("w1_done_count", done_cnt, 1);

    // single read
    clear_plan();
    rd[0] = 64'h0123456789ABCDEF;
    run_task(1'b0, 16'h0007, 4'd0);
    check("r1_data", last_rd, 64'h0123456789ABCDEF);
    check("r1_rd_count", rd_cnt, 1);
    check("r1_data_token", seen_tok[1], 19'h4B501);
    check("r1_data_pkt", seen_pkt[1], 72'h0);
    check("r1_success", last_success, 1);

    // burst read across the page wrap, with random ready and stray done pulses
    force_ready = 1'b0; no_spur = 1'b0;
    clear_plan();
    run_task(1'b0, 16'hFFFE, 4'd2);
    check("b_page_fffe", seen_pkt[0], 72'hC3_0000_0000_0000_7FFF);
    check("b_page_ffff", seen_pkt[2], 72'hC3_0000_0000_0000_FFFF);
    check("b_page_0000", seen_pkt[4], 72'hC3_0000_0000_0000_0000);
    check("b_rd_count", rd_cnt, 3);
    check("b_done_count", done_cnt, 1);

    // write whose data phase fails twice
    clear_plan();
    fd[0] = 2;
    run_task(1'b1, 16'h0010, 4'd0);
    check("wr_retry_starts", start_cnt, (EFF_MAXR >= 2) ? 4 : 2);
    check("wr_retry_fetch", fetch_cnt, 1);
    check("wr_retry_success", last_success, (EFF_MAXR >= 2) ? 1 : 0);

    // address phase that never succeeds
    clear_plan();
    fa[0] = 99;
    run_task(1'b0, 16'h0020, 4'd3);
    check("addr_fail_starts", start_cnt, EFF_MAXR + 1);
    check("addr_fail_success", last_success, 0);
    check("addr_fail_done_count", done_cnt, 1);

    // reserved task code is ignored
    tsk_drive = 2'b11;
    repeat (3) step();
    tsk_drive = 2'b00;

    // reset while waiting on the read data phase
    clear_plan();
    launch(1'b0, 16'h0042, 4'd0);
    for (int b = 0; b < 200 && start_cnt < 2; b++) step();
    check("rst_reached_data_phase", start_cnt, 2);
    hold_resp = 1'b1;
    step();
    apply_reset();
    repeat (2) step();
    check("rst_no_task_done", done_cnt, 0);
    clear_plan();
    run_task(1'b0, 16'h0100, 4'd1);
    check("post_rst_success", last_success, 1);
    check("post_rst_rd_count", rd_cnt, 2);

    // randomised tasks
    for (int t = 0; t < 40; t++) begin
      bit wr;
      logic [15:0] pg;
      clear_plan();
      for (int i = 0; i < 16; i++) begin
        fa[i] = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 4);
        fd[i] = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 4);
      end
      wr = 1'($urandom_range(0, 1));
      pg = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      resp_max = $urandom_range(0, 3);
      run_task(wr, pg, 4'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
